// File: rtl/n1_seq_8x8.sv
// Sequential 8x8 multiplier built from one shared 4x4 partial-product core,
// stepping through the four nibble pairs over four cycles and accumulating.

module n1_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] ll, lh, hl, hh;

  // 2x2 block reports 3*3 as 7 (drops one carry), so the core only underestimates
  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd3 && y == 2'd3) return 4'd7;
    return {2'b00, x} * {2'b00, y};
  endfunction

  always_comb begin
    ll = mul2(a[1:0], b[1:0]);
    lh = mul2(a[1:0], b[3:2]);
    hl = mul2(a[3:2], b[1:0]);
    hh = mul2(a[3:2], b[3:2]);
    p  = {4'b0000, ll} + {2'b00, lh, 2'b00} + {2'b00, hl, 2'b00} + {hh, 4'b0000};
  end
endmodule

module n1_seq_8x8 #(
  parameter bit EXACT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] y,
  output logic        ovf
);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PP0  = 3'd1;
  localparam logic [2:0] ST_PP1  = 3'd2;
  localparam logic [2:0] ST_PP2  = 3'd3;
  localparam logic [2:0] ST_PP3  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [7:0]  ra_q, ra_d, rb_q, rb_d;
  logic [16:0] acc_q, acc_d;
  logic [15:0] y_q, y_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic [3:0]  core_a, core_b;
  logic [7:0]  core_p;
  logic [16:0] pp_shift, sum;

  always_comb begin
    core_a = 4'd0;
    core_b = 4'd0;
    case (state_q)
      ST_PP0:  begin core_a = ra_q[3:0]; core_b = rb_q[3:0]; end
      ST_PP1:  begin core_a = ra_q[3:0]; core_b = rb_q[7:4]; end
      ST_PP2:  begin core_a = ra_q[7:4]; core_b = rb_q[3:0]; end
      ST_PP3:  begin core_a = ra_q[7:4]; core_b = rb_q[7:4]; end
      default: begin core_a = 4'd0;      core_b = 4'd0;      end
    endcase
  end

  generate
    if (EXACT) begin : g_exact
      assign core_p = {4'b0000, core_a} * {4'b0000, core_b};
    end else begin : g_approx
      n1_4x4 u_core (
        .a(core_a),
        .b(core_b),
        .p(core_p)
      );
    end
  endgenerate

  always_comb begin
    case (state_q)
      ST_PP0:         pp_shift = {9'd0, core_p};
      ST_PP1, ST_PP2: pp_shift = {5'd0, core_p, 4'd0};
      ST_PP3:         pp_shift = {1'b0, core_p, 8'd0};
      default:        pp_shift = 17'd0;
    endcase
    sum = acc_q + pp_shift;
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          acc_d   = 17'd0;
          state_d = ST_PP0;
        end
      end
      ST_PP0: begin acc_d = sum; state_d = ST_PP1; end
      ST_PP1: begin acc_d = sum; state_d = ST_PP2; end
      ST_PP2: begin acc_d = sum; state_d = ST_PP3; end
      ST_PP3: begin
        acc_d   = sum;
        y_d     = sum[15:0];
        ovf_d   = sum[16];
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= 8'd0;
      rb_q    <= 8'd0;
      acc_q   <= 17'd0;
      y_q     <= 16'd0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign y    = y_q;
  assign ovf  = ovf_q;
endmodule
